product_accumulator: RTL
========================

# product_accumulator

Sequential accumulator sitting directly downstream of the 4x4 array multiplier: it consumes the 8-bit product `P` one term per cycle and sums a frame of products into a wider result. It provides dot-product / multiply-accumulate capability on top of the purely combinational multiplier. Upstream and downstream transfers use valid/ready handshakes, so the block can sit between an operand sequencer and any result consumer.

## Interface
- `ACC_W`, 12, accumulator/result width in bits; must be ≥ 8. Default holds 16 × 225 = 3600 without overflow.
- `MAX_TERMS`, 16, maximum products per frame; frame auto-closes at this count; must be ≥ 1.
- `clk` input 1 — single clock, all state on rising edge.
- `rst_n` input 1 — reset, asynchronous and active-low.
- `in_valid` input 1 — `P`/`in_last` valid this cycle.
- `in_ready` output 1 — block can accept a product this cycle.
- `P` input 8 — unsigned product from the multiplier.
- `in_last` input 1 — this term closes the frame.
- `out_valid` output 1 — `SUM`/`COUNT`/`OVF` hold a completed frame.
- `out_ready` input 1 — consumer takes the result this cycle.
- `SUM` output ACC_W — unsigned frame sum, saturated.
- `COUNT` output $clog2(MAX_TERMS)+1 — number of terms in the frame.
- `OVF` output 1 — frame sum exceeded 2^ACC_W−1.

## Operation
- States: IDLE (no partial frame), ACCUM (≥1 term accepted, frame open), DONE (result presented).
- `in_ready` = 1 in IDLE and ACCUM, 0 in DONE. `out_valid` = 1 exactly in DONE.
- Accept = `in_valid & in_ready` at a rising edge.
- Accept in IDLE: acc ← `P` (zero-extended), count ← 1, ovf ← 0.
- Accept in ACCUM: acc ← acc + `P`, count ← count + 1.
- Addition is computed ACC_W+1 bits wide. On carry-out, or if acc is already saturated, acc ← all ones and ovf ← 1 (sticky for the frame). No wrap-around ever.
- Frame close on an accept: if `in_last` = 1 or the new count = MAX_TERMS → DONE. Otherwise → ACCUM. A close from IDLE (single-term frame) goes straight to DONE.
- `in_valid` = 0 in ACCUM: hold state and acc indefinitely. No timeout.
- DONE with `out_ready` = 1 → IDLE. With `out_ready` = 0, hold `SUM`/`COUNT`/`OVF` stable.
- `in_valid` asserted in DONE is ignored, not consumed; upstream must hold it.
- `SUM`, `COUNT`, `OVF` are driven from registers at all times and are meaningful only while `out_valid` = 1. In IDLE/ACCUM they show the running partial values.
- `P` and `in_last` are don't-care when `in_valid` = 0.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `SUM` = 0, `COUNT` = 0, `OVF` = 0, `out_valid` = 0, `in_ready` = 1 (combinational from state).
- Reset asserted mid-frame or in DONE discards the partial or pending result. No output pulse on reset release.
- Latency: `out_valid` rises in the cycle after the edge that accepts the closing term.
- Throughput: one product per cycle within a frame.
- Frame gap: at least one cycle of DONE (`in_ready` = 0) between frames. The result handshake and the first accept of the next frame never occur in the same cycle.
- `in_ready` depends only on state, never combinationally on `in_valid` or `out_ready`.

## Test plan
- Three accepts of `P` = 225 back-to-back, `in_last` on the third → next cycle `out_valid` = 1, `SUM` = 675, `COUNT` = 3, `OVF` = 0. `out_ready` = 1 → IDLE the following cycle.
- Sixteen accepts of `P` = 225, `in_last` never set → auto-close, `SUM` = 3600, `COUNT` = 16, `OVF` = 0.
- ACC_W = 8: `P` = 200, then `P` = 100 with `in_last` → `SUM` = 255, `OVF` = 1. Next frame of a single `P` = 5 → `SUM` = 5, `OVF` = 0.
- Backpressure: frame `P` = 10, 20 (last), then `out_ready` = 0 for 5 cycles with `in_valid` = 1 and `P` = 7 → `SUM` stays 30, `in_ready` = 0. After `out_ready` is raised, `P` = 7 is accepted in IDLE on a later cycle.
- Gaps: `P` = 3, two idle cycles, `P` = 4 (last) → `SUM` = 7, `COUNT` = 2. Single-term frame `P` = 0 with last → `SUM` = 0, `COUNT` = 1.
- Drop `rst_n` asynchronously after two accepts (`P` = 50, 60) → outputs 0 immediately. After release, `P` = 1 (last) → `SUM` = 1, `COUNT` = 1.

Source files
------------

// File: rtl/product_accumulator.sv
// Frame accumulator behind the 4x4 multiplier: sums unsigned 8-bit products per frame
// with saturation, valid/ready on both sides, and one DONE cycle minimum between frames.
module product_accumulator #(
    parameter int ACC_W     = 12,
    parameter int MAX_TERMS = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   P,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             SUM,
    output logic [$clog2(MAX_TERMS):0]   COUNT,
    output logic                         OVF
);

    localparam int CNT_W = $clog2(MAX_TERMS) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] count, count_next;
    logic             ovf, ovf_next;
    logic [ACC_W:0]   add_res;

    // Returns {overflow, value}; once saturated the frame stays pinned at all ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [7:0]       p,
                                               input logic             sat);
        logic [ACC_W:0] wide;
        wide = {1'b0, a} + (ACC_W+1)'(p);
        if (wide[ACC_W] || sat)
            return {1'b1, {ACC_W{1'b1}}};
        return wide;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        count_next = count;
        ovf_next   = ovf;
        in_ready   = (state != DONE);
        out_valid  = (state == DONE);
        add_res    = sat_add(acc, P, ovf);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_next   = ACC_W'(P);
                    count_next = ONE_CNT;
                    ovf_next   = 1'b0;
                    state_next = (in_last || ONE_CNT == MAX_CNT) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_next   = add_res[ACC_W-1:0];
                    ovf_next   = add_res[ACC_W];
                    count_next = count + ONE_CNT;
                    state_next = (in_last || (count + ONE_CNT) == MAX_CNT) ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign SUM   = acc;
    assign COUNT = count;
    assign OVF   = ovf;

endmodule
